data_mem_unit: RTL and testbench

Data-side memory stage that sits directly downstream of the 5-stage core's MA stage. It consumes the core's wem/rwmm/rwam/wdm and returns rdm combinationally in the same cycle, so the core's MA->WB flop captures it. It contains a byte-addressable data RAM with RISC-V funct3 access modes (sign/zero extension, byte-lane stores). It also provides a small MMIO region: a free-running cycle counter, and a TX byte FIFO drained through a valid/ready handshake.

---
 rtl/data_mem_unit.sv | 189 ++++++++++++++++++
 tb/tb_data_mem_unit.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Data-side memory stage: byte-addressable RAM with RISC-V load/store modes,
// plus a small MMIO window holding a cycle counter and a TX byte FIFO.
module data_mem_unit #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wem,
  input  logic [2:0]  rwmm,
  input  logic [31:0] rwam,
  input  logic [31:0] wdm,
  output logic [31:0] rdm,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          overflow;
  logic [31:0]   cycle_count;

  logic          is_supported;
  logic          is_misaligned;
  logic          is_mmio;
  logic          access_ok;
  logic [1:0]    reg_sel;
  logic [AW-1:0] word_idx;
  logic [31:0]   ram_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   status_word;
  logic [3:0]    byte_en;
  logic [31:0]   wr_data;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          full;
  logic          status_clr;

  assign word_idx = rwam[AW+1:2];
  assign ram_word = mem[word_idx];
  assign is_mmio  = (rwam[31:4] == MMIO_BASE[31:4]);
  assign reg_sel  = rwam[3:2];

  // Classify the access mode: supported encodings and alignment by access size.
  always_comb begin
    is_supported  = 1'b0;
    is_misaligned = 1'b0;
    case (rwmm)
      MODE_B, MODE_BU: is_supported = 1'b1;
      MODE_H, MODE_HU: begin
        is_supported  = 1'b1;
        is_misaligned = rwam[0];
      end
      MODE_W: begin
        is_supported  = 1'b1;
        is_misaligned = (rwam[1:0] != 2'b00);
      end
      default: is_supported = 1'b0;
    endcase
    access_ok = is_supported && !is_misaligned;
  end

  // Assemble the STATUS register from FIFO occupancy and the overflow flag.
  always_comb begin
    status_word             = '0;
    status_word[0]          = full;
    status_word[1]          = (count == '0);
    status_word[2+PW:2]     = count;
    status_word[3+PW]       = overflow;
  end

  // Combinational load path: MMIO registers whole, RAM with lane extraction.
  always_comb begin
    rdm      = '0;
    byte_sel = ram_word[8*rwam[1:0] +: 8];
    half_sel = rwam[1] ? ram_word[31:16] : ram_word[15:0];
    if (access_ok) begin
      if (is_mmio) begin
        case (reg_sel)
          2'd0:    rdm = cycle_count;
          2'd2:    rdm = status_word;
          default: rdm = '0;
        endcase
      end else begin
        case (rwmm)
          MODE_B:  rdm = {{24{byte_sel[7]}}, byte_sel};
          MODE_BU: rdm = {24'h0, byte_sel};
          MODE_H:  rdm = {{16{half_sel[15]}}, half_sel};
          MODE_HU: rdm = {16'h0, half_sel};
          MODE_W:  rdm = ram_word;
          default: rdm = '0;
        endcase
      end
    end
  end

  // Byte enables and lane-replicated store data for RAM stores.
  always_comb begin
    byte_en = '0;
    wr_data = '0;
    if (wem && access_ok && !is_mmio) begin
      case (rwmm)
        MODE_B, MODE_BU: begin
          byte_en[rwam[1:0]] = 1'b1;
          wr_data            = {4{wdm[7:0]}};
        end
        MODE_H, MODE_HU: begin
          byte_en = rwam[1] ? 4'b1100 : 4'b0011;
          wr_data = {2{wdm[15:0]}};
        end
        MODE_W: begin
          byte_en = 4'b1111;
          wr_data = wdm;
        end
        default: byte_en = '0;
      endcase
    end
  end

  // RAM byte-lane writes; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  assign full       = (count == FULL_COUNT);
  assign tx_valid   = (count != '0);
  assign tx_data    = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign pop        = tx_valid && tx_ready;
  assign push_req   = wem && access_ok && is_mmio && (reg_sel == 2'd1);
  assign push_ok    = push_req && (!full || pop);
  assign status_clr = wem && access_ok && is_mmio && (reg_sel == 2'd2);

  // FIFO storage; a push while full is still accepted when a pop frees the slot.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= wdm[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (status_clr)                   overflow <= 1'b0;
      else if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  // Free-running cycle counter and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count  <= '0;
      misalign_err <= 1'b0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (is_misaligned) misalign_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: directed scenarios plus a randomized
// run compared against a byte-array / queue reference model.
module tb_data_mem_unit;

  localparam int          DEPTH_WORDS = 1024;
  localparam int          FIFO_DEPTH  = 4;
  localparam int          PW          = 2;
  localparam logic [31:0] MMIO_BASE   = 32'hFFFF_0000;

  localparam logic [2:0] M_B  = 3'b000;
  localparam logic [2:0] M_H  = 3'b001;
  localparam logic [2:0] M_W  = 3'b010;
  localparam logic [2:0] M_BU = 3'b100;
  localparam logic [2:0] M_HU = 3'b101;

  logic        clk;
  logic        reset;
  logic        wem;
  logic [2:0]  rwmm;
  logic [31:0] rwam;
  logic [31:0] wdm;
  logic [31:0] rdm;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  logic [7:0]  ref_bytes [0:4095];
  logic [31:0] ref_cycle;
  logic [7:0]  ref_q [$];
  bit          ref_ov;
  bit          ref_merr;

  data_mem_unit #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MMIO_BASE  (MMIO_BASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wem         (wem),
    .rwmm        (rwmm),
    .rwam        (rwam),
    .wdm         (wdm),
    .rdm         (rdm),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_supported(input logic [2:0] m);
    return (m == M_B) || (m == M_H) || (m == M_W) || (m == M_BU) || (m == M_HU);
  endfunction

  function automatic bit model_misaligned(input logic [31:0] a, input logic [2:0] m);
    if (m == M_H || m == M_HU) return (a % 2) != 0;
    if (m == M_W) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_status();
    int n;
    logic [31:0] s;
    n = ref_q.size();
    s = 32'(n * 4);
    if (n == 0) s = s + 32'd2;
    if (n == FIFO_DEPTH) s = s + 32'd1;
    if (ref_ov) s = s + 32'(1 << (3 + PW));
    return s;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] m);
    logic [11:0] base;
    logic [11:0] hoff;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    if (!model_supported(m) || model_misaligned(a, m)) return 32'h0;
    if (a[31:4] == MMIO_BASE[31:4]) begin
      if (a[3:2] == 2'd0) return ref_cycle;
      if (a[3:2] == 2'd2) return model_status();
      return 32'h0;
    end
    base = {a[11:2], 2'b00};
    hoff = a[1] ? 12'd2 : 12'd0;
    b = ref_bytes[a[11:0]];
    h = {ref_bytes[base + hoff + 12'd1], ref_bytes[base + hoff]};
    w = {ref_bytes[base + 12'd3], ref_bytes[base + 12'd2], ref_bytes[base + 12'd1], ref_bytes[base]};
    case (m)
      M_B:     return {{24{b[7]}}, b};
      M_BU:    return {24'h0, b};
      M_H:     return {{16{h[15]}}, h};
      M_HU:    return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Advance the reference model across one rising edge with the given inputs.
  function automatic void model_edge(input logic w, input logic [2:0] m, input logic [31:0] a,
                                     input logic [31:0] d, input logic rdy);
    bit ok;
    bit do_pop;
    int n;
    logic [11:0] base;
    ok = model_supported(m) && !model_misaligned(a, m);
    if (model_supported(m) && model_misaligned(a, m)) ref_merr = 1'b1;
    n = ref_q.size();
    do_pop = (n != 0) && rdy;
    if (do_pop) void'(ref_q.pop_front());
    if (ok && w && a[31:4] == MMIO_BASE[31:4]) begin
      if (a[3:2] == 2'd1) begin
        if (n < FIFO_DEPTH || do_pop) ref_q.push_back(d[7:0]);
        else ref_ov = 1'b1;
      end
      if (a[3:2] == 2'd2) ref_ov = 1'b0;
    end else if (ok && w) begin
      base = {a[11:2], 2'b00};
      if (m == M_B || m == M_BU) ref_bytes[a[11:0]] = d[7:0];
      else if (m == M_H || m == M_HU) begin
        ref_bytes[a[11:0]]         = d[7:0];
        ref_bytes[a[11:0] + 12'd1] = d[15:8];
      end else begin
        for (int i = 0; i < 4; i++) ref_bytes[base + 12'(i)] = d[8*i +: 8];
      end
    end
    ref_cycle = ref_cycle + 32'd1;
  endfunction

  // One bus cycle: present inputs, capture rdm mid-cycle, cross the edge.
  task automatic step(input logic w, input logic [2:0] m, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd);
    wem  = w;
    rwmm = m;
    rwam = a;
    wdm  = d;
    @(negedge clk);
    rd = rdm;
    model_edge(w, m, a, d, tx_ready);
    @(posedge clk);
    #1;
    wem  = 1'b0;
    rwmm = M_W;
    rwam = 32'h0;
    wdm  = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wem   = 1'b0;
    rwmm  = M_W;
    rwam  = 32'h0;
    wdm   = 32'h0;
    @(negedge clk);
    ref_cycle = 32'h0;
    ref_q.delete();
    ref_ov   = 1'b0;
    ref_merr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic init_ram();
    logic [31:0] rd;
    for (int i = 0; i < 64; i++) step(1'b1, M_W, 32'(i * 4), $urandom, rd);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    tx_ready = 1'b0;
    do_reset();
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_tx: tx_valid=%b tx_data=%h, required 0/00", tx_valid, tx_data);
    end
    checks++;
    if (misalign_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_merr: got %b, required 0", misalign_err);
    end
    step(1'b0, M_W, MMIO_BASE + 32'h8, 32'h0, rd);
    checks++;
    if (rd !== 32'h0000_0002) begin
      errors++;
      $display("[TB] FAIL reset_status: got %h, required 00000002", rd);
    end
  endtask

  task automatic test_extension();
    logic [31:0] rd;
    logic [31:0] exp_v [5];
    logic [31:0] addr_v [5];
    logic [2:0]  mode_v [5];
    exp_v  = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8000, 32'h0000_8000, 32'h8000_80F0};
    addr_v = '{32'h10, 32'h10, 32'h12, 32'h12, 32'h10};
    mode_v = '{M_B, M_BU, M_H, M_HU, M_W};
    step(1'b1, M_W, 32'h10, 32'h8000_80F0, rd);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, mode_v[i], addr_v[i], 32'h0, rd);
      checks++;
      if (rd !== exp_v[i]) begin
        errors++;
        $display("[TB] FAIL extension_%0d: mode=%b got %h, required %h", i, mode_v[i], rd, exp_v[i]);
      end
    end
  endtask

  task automatic test_byte_lane();
    logic [31:0] rd;
    step(1'b1, M_W, 32'h20, 32'h1122_3344, rd);
    step(1'b1, M_B, 32'h21, 32'h0000_00AA, rd);
    checks++;
    if (rd !== 32'h0000_0033) begin
      errors++;
      $display("[TB] FAIL sb_same_cycle: got %h, required 00000033", rd);
    end
    step(1'b1, M_H, 32'h22, 32'h0000_BEEF, rd);
    step(1'b0, M_W, 32'h20, 32'h0, rd);
    checks++;
    if (rd !== 32'hBEEF_AA44) begin
      errors++;
      $display("[TB] FAIL byte_lane_word: got %h, required beefaa44", rd);
    end
    step(1'b1, M_W, 32'h24, 32'h0102_0304, rd);
    step(1'b1, M_W, 32'h24, 32'hDEAD_BEEF, rd);
    checks++;
    if (rd !== 32'h0102_0304) begin
      errors++;
      $display("[TB] FAIL sw_same_cycle: got %h, required 01020304", rd);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd;
    step(1'b1, M_W, 32'h30, 32'h1234_5678, rd);
    step(1'b1, 3'b011, 32'h30, 32'hFFFF_FFFF, rd);
    checks++;
    if (rd !== 32'h0 || misalign_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unsupported_mode: rd=%h err=%b, required 0/0", rd, misalign_err);
    end
    step(1'b1, M_W, 32'h31, 32'h0000_0005, rd);
    checks++;
    if (misalign_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL merr_set: got %b, required 1", misalign_err);
    end
    step(1'b0, M_W, 32'h30, 32'h0, rd);
    checks++;
    if (rd !== 32'h1234_5678 || misalign_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL merr_store_suppressed: rd=%h err=%b, required 12345678/1", rd, misalign_err);
    end
    step(1'b0, M_H, 32'h33, 32'h0, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("[TB] FAIL misaligned_load: got %h, required 0", rd);
    end
    do_reset();
    checks++;
    if (misalign_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL merr_cleared: got %b, required 0", misalign_err);
    end
  endtask

  task automatic test_cycle_counter();
    logic [31:0] rd;
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, M_W, 32'h0, 32'h0, rd);
    step(1'b0, M_W, MMIO_BASE, 32'h0, rd);
    checks++;
    if (rd !== 32'd10) begin
      errors++;
      $display("[TB] FAIL cycle_10: got %0d, required 10", rd);
    end
    step(1'b1, M_W, MMIO_BASE, 32'h0000_1234, rd);
    step(1'b0, M_W, MMIO_BASE, 32'h0, rd);
    checks++;
    if (rd !== 32'd12) begin
      errors++;
      $display("[TB] FAIL cycle_after_store: got %0d, required 12", rd);
    end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] rd;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, M_W, MMIO_BASE + 32'h4, 32'(8'h41 + i), rd);
    step(1'b0, M_W, MMIO_BASE + 32'h8, 32'h0, rd);
    checks++;
    if (rd !== 32'h0000_0031 || tx_data !== 8'h41) begin
      errors++;
      $display("[TB] FAIL fifo_full_status: status=%h tx_data=%h, required 00000031/41", rd, tx_data);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        errors++;
        $display("[TB] FAIL fifo_drain_%0d: valid=%b data=%h, required 1/%h", i, tx_valid, tx_data, 8'(8'h41 + i));
      end
      step(1'b0, M_W, 32'h0, 32'h0, rd);
    end
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fifo_empty_valid: got %b, required 0", tx_valid);
    end
    step(1'b0, M_W, MMIO_BASE + 32'h8, 32'h0, rd);
    checks++;
    if (rd !== 32'h0000_0022) begin
      errors++;
      $display("[TB] FAIL fifo_empty_status: got %h, required 00000022", rd);
    end
    step(1'b1, M_W, MMIO_BASE + 32'h8, 32'h0, rd);
    step(1'b0, M_W, MMIO_BASE + 32'h8, 32'h0, rd);
    checks++;
    if (rd !== 32'h0000_0002) begin
      errors++;
      $display("[TB] FAIL overflow_clear: got %h, required 00000002", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [7:0]  exp_seq [4];
    exp_seq = '{8'h62, 8'h63, 8'h64, 8'h55};
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, M_W, MMIO_BASE + 32'h4, 32'(8'h61 + i), rd);
    tx_ready = 1'b1;
    step(1'b1, M_W, MMIO_BASE + 32'h4, 32'h55, rd);
    tx_ready = 1'b0;
    step(1'b0, M_W, MMIO_BASE + 32'h8, 32'h0, rd);
    checks++;
    if (rd !== 32'h0000_0011) begin
      errors++;
      $display("[TB] FAIL full_push_pop_status: got %h, required 00000011", rd);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_seq[i]) begin
        errors++;
        $display("[TB] FAIL full_push_pop_order_%0d: valid=%b data=%h, required 1/%h", i, tx_valid, tx_data, exp_seq[i]);
      end
      step(1'b0, M_W, 32'h0, 32'h0, rd);
    end
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, M_W, MMIO_BASE + 32'h4, 32'(8'h70 + i), rd);
    do_reset();
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_reset_valid: got %b, required 0", tx_valid);
    end
    step(1'b0, M_W, MMIO_BASE, 32'h0, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midop_reset_cycle: got %h, required 0", rd);
    end
    step(1'b0, M_W, MMIO_BASE + 32'h8, 32'h0, rd);
    checks++;
    if (rd !== 32'h0000_0002) begin
      errors++;
      $display("[TB] FAIL midop_reset_status: got %h, required 00000002", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] exp_rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  m;
    logic        w;
    logic [2:0]  st_modes [4];
    logic [2:0]  ld_modes [6];
    st_modes = '{M_B, M_H, M_W, 3'b011};
    ld_modes = '{M_B, M_H, M_W, M_BU, M_HU, 3'b110};
    for (int i = 0; i < 300; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        m = w ? st_modes[$urandom_range(0, 3)] : ld_modes[$urandom_range(0, 5)];
        a = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 19) != 0) begin
          if (m == M_H || m == M_HU) a[0] = 1'b0;
          if (m == M_W) a[1:0] = 2'b00;
        end
      end else begin
        m = M_W;
        a = MMIO_BASE + 32'($urandom_range(0, 3) * 4);
      end
      exp_rd = model_load(a, m);
      step(w, m, a, d, rd);
      checks++;
      if (rd !== exp_rd) begin
        errors++;
        $display("[TB] FAIL rand_rdm_%0d: a=%h m=%b got %h, required %h", i, a, m, rd, exp_rd);
      end
      checks++;
      if (tx_valid !== (ref_q.size() != 0) ||
          tx_data !== ((ref_q.size() != 0) ? ref_q[0] : 8'h00) ||
          misalign_err !== ref_merr) begin
        errors++;
        $display("[TB] FAIL rand_state_%0d: valid=%b data=%h err=%b, required %b/%h/%b", i,
                 tx_valid, tx_data, misalign_err, (ref_q.size() != 0),
                 ((ref_q.size() != 0) ? ref_q[0] : 8'h00), ref_merr);
      end
    end
    tx_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    wem       = 1'b0;
    rwmm      = M_W;
    rwam      = 32'h0;
    wdm       = 32'h0;
    tx_ready  = 1'b0;
    ref_cycle = 32'h0;
    ref_ov    = 1'b0;
    ref_merr  = 1'b0;
    test_reset();
    init_ram();
    test_extension();
    test_byte_lane();
    test_misalign();
    test_cycle_counter();
    test_fifo_overflow();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
